assoc_top_short: RTL and testbench

ASSOC_TOP_SHORT -- requirements
Module: assoc_top_short

---
 rtl/assoc_top_short.sv | 142 ++++++++++++++
 tb/tb_assoc_top_short.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/assoc_top_short.sv
// Associative-memory classifier: scans 26 class hypervectors one per cycle and
// reports the index with the largest overlap (popcount of AND) with the query.
module assoc_top_short (
  input  logic        clk,
  input  logic        nrst,
  input  logic        input_ready,
  input  logic [49:0] query_hv,
  input  logic [4:0]  query_class,
  input  logic [49:0] a, b, c, d, e, f, g, h, i, j, k, l, m,
  input  logic [49:0] n, o, p, q, r, s, t, u, v, w, x, y, z,
  output logic [4:0]  inference,
  output logic [4:0]  inference_reg,
  output logic [49:0] hv_pipe,
  output logic [4:0]  class_pipe,
  output logic        enable,
  output logic [3:0]  state,
  output logic        infer_done
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] COMPARE = 4'd1;
  localparam logic [3:0] DONE    = 4'd2;
  localparam logic [3:0] WAIT    = 4'd3;
  localparam logic [4:0] LAST_IDX = 5'd25;

  logic [3:0]  state_q, state_d;
  logic [4:0]  counter_q, counter_d;
  logic [5:0]  best_q, best_d;
  logic [4:0]  inf_q, inf_d;
  logic [4:0]  infreg_q, infreg_d;
  logic [49:0] hv_q, hv_d;
  logic [4:0]  cls_q, cls_d;

  logic [49:0] class_sel;
  logic [5:0]  score;

  always_comb begin
    class_sel = '0;
    case (counter_q)
      5'd0:  class_sel = a;
      5'd1:  class_sel = b;
      5'd2:  class_sel = c;
      5'd3:  class_sel = d;
      5'd4:  class_sel = e;
      5'd5:  class_sel = f;
      5'd6:  class_sel = g;
      5'd7:  class_sel = h;
      5'd8:  class_sel = i;
      5'd9:  class_sel = j;
      5'd10: class_sel = k;
      5'd11: class_sel = l;
      5'd12: class_sel = m;
      5'd13: class_sel = n;
      5'd14: class_sel = o;
      5'd15: class_sel = p;
      5'd16: class_sel = q;
      5'd17: class_sel = r;
      5'd18: class_sel = s;
      5'd19: class_sel = t;
      5'd20: class_sel = u;
      5'd21: class_sel = v;
      5'd22: class_sel = w;
      5'd23: class_sel = x;
      5'd24: class_sel = y;
      5'd25: class_sel = z;
      default: class_sel = '0;
    endcase
  end

  always_comb begin
    score = '0;
    for (int unsigned bi = 0; bi < 50; bi++) begin
      score = score + 6'(hv_q[bi] & class_sel[bi]);
    end
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    best_d    = best_q;
    inf_d     = inf_q;
    infreg_d  = infreg_q;
    hv_d      = hv_q;
    cls_d     = cls_q;
    case (state_q)
      IDLE: begin
        if (input_ready) begin
          hv_d      = query_hv;
          cls_d     = query_class;
          best_d    = '0;
          inf_d     = '0;
          counter_d = '0;
          state_d   = COMPARE;
        end
      end
      COMPARE: begin
        // Strict '>' keeps the lowest index among equal maxima.
        if (score > best_q) begin
          best_d = score;
          inf_d  = counter_q;
        end
        counter_d = counter_q + 5'd1;
        if (counter_q == LAST_IDX) begin
          infreg_d = (score > best_q) ? counter_q : inf_q;
          state_d  = DONE;
        end
      end
      DONE:    state_d = WAIT;
      WAIT:    if (!input_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      best_q    <= '0;
      inf_q     <= '0;
      infreg_q  <= '0;
      hv_q      <= '0;
      cls_q     <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      best_q    <= best_d;
      inf_q     <= inf_d;
      infreg_q  <= infreg_d;
      hv_q      <= hv_d;
      cls_q     <= cls_d;
    end
  end

  assign inference     = inf_q;
  assign inference_reg = infreg_q;
  assign hv_pipe       = hv_q;
  assign class_pipe    = cls_q;
  assign state         = state_q;
  assign enable        = (state_q == COMPARE);
  assign infer_done    = (state_q == DONE);

endmodule

// File: tb/tb_assoc_top_short.sv
// Directed bench for assoc_top_short with a queue-based scoreboard of expected
// final class indices, compared when infer_done pulses.
module tb_assoc_top_short;

  logic        clk = 1'b0;
  logic        nrst;
  logic        input_ready;
  logic [49:0] query_hv;
  logic [4:0]  query_class;
  logic [49:0] cls [26];
  logic [4:0]  inference, inference_reg, class_pipe;
  logic [49:0] hv_pipe;
  logic        enable, infer_done;
  logic [3:0]  state;

  int checks = 0;
  int failures = 0;
  logic [4:0] sb_q [$];

  always #5 clk = ~clk;

  assoc_top_short dut (
    .clk(clk), .nrst(nrst), .input_ready(input_ready),
    .query_hv(query_hv), .query_class(query_class),
    .a(cls[0]),  .b(cls[1]),  .c(cls[2]),  .d(cls[3]),  .e(cls[4]),
    .f(cls[5]),  .g(cls[6]),  .h(cls[7]),  .i(cls[8]),  .j(cls[9]),
    .k(cls[10]), .l(cls[11]), .m(cls[12]), .n(cls[13]), .o(cls[14]),
    .p(cls[15]), .q(cls[16]), .r(cls[17]), .s(cls[18]), .t(cls[19]),
    .u(cls[20]), .v(cls[21]), .w(cls[22]), .x(cls[23]), .y(cls[24]),
    .z(cls[25]),
    .inference(inference), .inference_reg(inference_reg),
    .hv_pipe(hv_pipe), .class_pipe(class_pipe), .enable(enable),
    .state(state), .infer_done(infer_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_best(input logic [49:0] hv);
    int best_s = 0;
    logic [4:0] best_i = 5'd0;
    for (int ci = 0; ci < 26; ci++) begin
      int sc = $countones(hv & cls[ci]);
      if (sc > best_s) begin
        best_s = sc;
        best_i = 5'(ci);
      end
    end
    return best_i;
  endfunction

  // Starts a search at a negedge, holds input_ready high for 35 cycles while
  // scrambling query inputs, then drops it for one cycle.
  task automatic run_search(input string tag, input logic [49:0] hv, input logic [4:0] qc);
    int en_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    logic [4:0] exp_idx;
    @(negedge clk);
    query_hv    = hv;
    query_class = qc;
    input_ready = 1'b1;
    sb_q.push_back(model_best(hv));
    for (int cyc = 1; cyc <= 35; cyc++) begin
      @(negedge clk);
      if (cyc == 4) begin
        query_hv    = {$urandom, $urandom};
        query_class = 5'($urandom);
      end
      if (enable) en_cnt++;
      if (infer_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (sb_q.size() > 0) begin
          exp_idx = sb_q.pop_front();
          chk({tag, "_inference_reg"}, 64'(inference_reg), 64'(exp_idx));
        end
      end
    end
    chk({tag, "_enable_cycles"}, 64'(en_cnt), 64'd26);
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_done_latency"}, 64'(done_cyc), 64'd27);
    chk({tag, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    chk({tag, "_state_wait"}, 64'(state), 64'd3);
    chk({tag, "_hv_pipe"}, 64'(hv_pipe), 64'(hv));
    chk({tag, "_class_pipe"}, 64'(class_pipe), 64'(qc));
    input_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_back_idle"}, 64'(state), 64'd0);
  endtask

  initial begin
    logic [49:0] rhv;
    int early_done;
    nrst        = 1'b0;
    input_ready = 1'b1;
    query_hv    = 50'h3_FFFF_FFFF_FFFF;
    query_class = 5'd31;
    cls[0]  = 50'hFFFF;        cls[1]  = 50'hFF;         cls[2]  = 50'hF0000;
    cls[3]  = 50'hFFFFF;       cls[4]  = 50'hFFF00;      cls[5]  = 50'hF000F;
    cls[6]  = 50'hFFFFFF;      cls[7]  = 50'hFFF00F;     cls[8]  = 50'hFFFFFFF;
    cls[9]  = 50'hFFFFFFFFF;   cls[10] = 50'h11;         cls[11] = 50'h12;
    cls[12] = 50'h100001;      cls[13] = 50'hF;          cls[14] = 50'h5;
    cls[15] = 50'h56;          cls[16] = 50'hFFFFFFFF;   cls[17] = 50'h65;
    cls[18] = 50'h8;           cls[19] = 50'h2;          cls[20] = 50'h756;
    cls[21] = 50'hFFF;         cls[22] = 50'h777;        cls[23] = 50'hF000000001;
    cls[24] = 50'hF000000001;  cls[25] = 50'hF000000000;

    repeat (3) @(negedge clk);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_outputs", {inference, inference_reg, class_pipe, enable, infer_done}, 64'd0);
    chk("rst_hv_pipe", 64'(hv_pipe), 64'd0);
    input_ready = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_wait", 64'(state), 64'd0);

    run_search("jmax", 50'hFFFFFFFFFF, 5'd3);
    chk("jmax_value", 64'(inference_reg), 64'd9);
    run_search("xytie", 50'hF000000001, 5'd5);
    chk("xytie_value", 64'(inference_reg), 64'd23);
    run_search("zero", 50'h0, 5'd7);
    chk("zero_value", 64'(inference_reg), 64'd0);

    for (int t = 0; t < 3; t++) begin
      rhv = {$urandom, $urandom};
      run_search("rand", rhv, 5'($urandom));
    end

    // Abort mid-scan: reset must clear everything and suppress the pulse.
    @(negedge clk);
    query_hv    = 50'hFFFFFFFFFF;
    query_class = 5'd9;
    input_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_in_compare", 64'(state), 64'd1);
    nrst = 1'b0;
    #1;
    chk("abort_state", 64'(state), 64'd0);
    chk("abort_outputs", {inference, inference_reg, class_pipe, enable, infer_done}, 64'd0);
    chk("abort_hv_pipe", 64'(hv_pipe), 64'd0);
    @(negedge clk);
    input_ready = 1'b0;
    nrst = 1'b1;
    early_done = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (infer_done) early_done++;
    end
    chk("abort_no_done", 64'(early_done), 64'd0);
    chk("abort_idle", 64'(state), 64'd0);
    run_search("after_abort", 50'hFFFFFFFFFF, 5'd3);
    chk("after_abort_value", 64'(inference_reg), 64'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
